button_gesture_decoder: RTL and testbench

Consumes the single-cycle `btn_pressed` / `btn_released` pulses produced by the debounced button front end and classifies each interaction as a short press, long press or double click. Sits between the button debouncer and the game control FSM. Downstream logic sees exactly one registered gesture pulse per completed interaction.

---
 rtl/button_gesture_decoder.sv | 111 +++++++++++
 tb/tb_button_gesture_decoder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/button_gesture_decoder.sv
// Classifies debounced press/release pulses into short press, long press and
// double click gestures; every gesture output is a registered one-cycle pulse.
module button_gesture_decoder #(
   parameter int CLK_FREQ        = 25_000_000,
   parameter int LONG_PRESS_MS   = 500,
   parameter int DOUBLE_CLICK_MS = 250
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_pressed,
   input  logic btn_released,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic held
);

   localparam int LONG_CYCLES = (CLK_FREQ / 1000) * LONG_PRESS_MS;
   localparam int DC_CYCLES   = (CLK_FREQ / 1000) * DOUBLE_CLICK_MS;
   localparam int MAX_CYCLES  = (LONG_CYCLES > DC_CYCLES) ? LONG_CYCLES : DC_CYCLES;
   localparam int CW          = $clog2(MAX_CYCLES + 1);

   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] DC_LAST   = CW'(DC_CYCLES - 1);
   localparam logic [CW-1:0] CNT_SAT   = '1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESSED1  = 3'd1,
      WAIT2     = 3'd2,
      PRESSED2  = 3'd3,
      LONG_HELD = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            short_d, long_d, dc_d, held_d;
   logic            ev_press, ev_release;

   // Simultaneous press and release is a protocol violation and counts as no event.
   assign ev_press   = btn_pressed  & ~btn_released;
   assign ev_release = btn_released & ~btn_pressed;

   always_comb begin
      state_d = state_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      dc_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ev_press) state_d = PRESSED1;
         end
         PRESSED1: begin
            if (ev_release) begin
               state_d = WAIT2;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG_HELD;
               long_d  = 1'b1;
            end
         end
         WAIT2: begin
            if (ev_press) begin
               state_d = PRESSED2;
            end else if (cnt_q == DC_LAST) begin
               state_d = IDLE;
               short_d = 1'b1;
            end
         end
         PRESSED2: begin
            if (ev_release) begin
               state_d = IDLE;
               dc_d    = 1'b1;
            end
         end
         LONG_HELD: begin
            if (ev_release) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      held_d = (state_d == LONG_HELD);
   end

   // Counter restarts on every state change and saturates instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q == PRESSED1 || state_q == WAIT2) && cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         double_click <= 1'b0;
         held         <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         short_press  <= short_d;
         long_press   <= long_d;
         double_click <= dc_d;
         held         <= held_d;
      end
   end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder: scenario table of input event
// cycles with hand-computed output cycles, plus a mid-gesture reset sequence.
module tb_button_gesture_decoder;

   localparam int NONE = -1;

   logic clk;
   logic rst_n;
   logic btn_pressed;
   logic btn_released;
   logic short_press;
   logic long_press;
   logic double_click;
   logic held;

   int checks;
   int errors;

   button_gesture_decoder #(
      .CLK_FREQ       (1000),
      .LONG_PRESS_MS  (10),
      .DOUBLE_CLICK_MS(5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_pressed (btn_pressed),
      .btn_released(btn_released),
      .short_press (short_press),
      .long_press  (long_press),
      .double_click(double_click),
      .held        (held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    p_a;
      int    r_a;
      int    p_b;
      int    r_b;
      int    both_c;
      int    short_c;
      int    long_c;
      int    dc_c;
      int    held_from;
      int    held_to;
      int    len;
   } scen_t;

   scen_t scen[7];

   // Compares {short_press, long_press, double_click, held} against exp.
   task automatic check_out(input string name, input int c, input logic [3:0] exp);
      logic [3:0] act;
      act = {short_press, long_press, double_click, held};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got s/l/d/h=%b expected %b", name, c, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      btn_pressed  = 1'b0;
      btn_released = 1'b0;
      repeat (2) @(negedge clk);
      check_out("reset", 0, 4'b0000);
      rst_n = 1'b1;
   endtask

   task automatic run_scen(input scen_t s);
      logic [3:0] exp;
      do_reset();
      for (int c = 0; c <= s.len; c++) begin
         @(posedge clk);
         #1;
         btn_pressed  = (c == s.p_a) || (c == s.p_b) || (c == s.both_c);
         btn_released = (c == s.r_a) || (c == s.r_b) || (c == s.both_c);
         @(negedge clk);
         exp = {c == s.short_c, c == s.long_c, c == s.dc_c,
                (c >= s.held_from) && (c <= s.held_to)};
         check_out(s.name, c, exp);
      end
      btn_pressed  = 1'b0;
      btn_released = 1'b0;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      btn_pressed  = 1'b0;
      btn_released = 1'b0;

      //           name          p_a   r_a   p_b   r_b   both  short long  dc    hfrom hto   len
      scen[0] = '{"short",       0,    3,    NONE, NONE, NONE, 9,    NONE, NONE, 999,  NONE, 15};
      scen[1] = '{"long",        0,    20,   NONE, NONE, NONE, NONE, 11,   NONE, 11,   20,   25};
      scen[2] = '{"double",      0,    2,    6,    30,   NONE, NONE, NONE, 31,   999,  NONE, 35};
      scen[3] = '{"rel_at_10",   0,    10,   NONE, NONE, NONE, 16,   NONE, NONE, 999,  NONE, 20};
      scen[4] = '{"press_r+5",   0,    2,    7,    9,    NONE, NONE, NONE, 10,   999,  NONE, 15};
      scen[5] = '{"press_r+6",   0,    2,    8,    NONE, NONE, 8,    19,   NONE, 19,   999,  22};
      scen[6] = '{"illegal",     3,    1,    NONE, 5,    0,    11,   NONE, NONE, 999,  NONE, 15};

      for (int i = 0; i < 7; i++) run_scen(scen[i]);

      // Reset mid-gesture: pending press is discarded, then a fresh short press works.
      do_reset();
      for (int c = 0; c <= 50; c++) begin
         @(posedge clk);
         #1;
         btn_pressed  = (c == 0) || (c == 41);
         btn_released = (c == 8) || (c == 42);
         if (c == 5) rst_n = 1'b0;
         if (c == 7) rst_n = 1'b1;
         @(negedge clk);
         check_out("mid_reset", c, {c == 48, 3'b000});
      end
      btn_pressed  = 1'b0;
      btn_released = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
